// File: rtl/beta_imem_arb_pkg.sv
// ============================================================================
// Module   : beta_imem_arb_pkg
// Brief    : Shared state encoding for the instruction-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package beta_imem_arb_pkg;

  localparam int arb_fsm_bsize = 2;

  typedef logic [arb_fsm_bsize-1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_WRDY = 2'd1;
  localparam arb_state_t ARB_WVLD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/beta_rr_picker.sv
// ============================================================================
// Module   : beta_rr_picker
// Brief    : Combinational round-robin picker; scans from i_last+1 with wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module beta_rr_picker #(
  parameter int NumReq = 2,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdxW-1:0]   i_last,
  output logic [NumReq-1:0] o_gnt,
  output logic [IdxW-1:0]   o_idx,
  output logic              o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 1; i <= NumReq; i++) begin : g_scan
      logic [IdxW-1:0] w_k;
      w_k = IdxW'((int'(i_last) + i) % NumReq);
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/beta_imem_arbiter.sv
// ============================================================================
// Module   : beta_imem_arbiter
// Brief    : Round-robin arbiter sharing one imem port, one transaction in flight.
//            Optional WVLD timeout enabled by macro BETA_IMEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module beta_imem_arbiter
  import beta_imem_arb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [NumReq-1:0]           arb_req_i,
  input  logic [NumReq*AddrWidth-1:0] arb_addr_i,
  output logic [NumReq-1:0]           arb_ready_o,
  output logic [NumReq-1:0]           arb_valid_o,
  output logic [DataWidth-1:0]        arb_rdata_o,
  output logic                        arb_busy_o,
  output logic                        mem_req_o,
  output logic [AddrWidth-1:0]        mem_addr_o,
  input  logic                        mem_ready_i,
  input  logic                        mem_valid_i,
  input  logic [DataWidth-1:0]        mem_rdata_i
`ifdef BETA_IMEM_ARB_TIMEOUT_EN
  ,
  output logic [NumReq-1:0]           arb_err_o
`endif
);

  localparam int IdxW = $clog2(NumReq);

  if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2) begin : g_param_check
    $error("beta_imem_arbiter: NumReq must be 2..8 and TimeoutCycles >= 2");
  end

  arb_state_t            r_state;
  logic [NumReq-1:0]     r_grant;
  logic [IdxW-1:0]       r_last;
  logic                  r_mem_req;
  logic [AddrWidth-1:0]  r_mem_addr;
  logic                  r_busy;

  logic [NumReq-1:0]     w_gnt;
  logic [IdxW-1:0]       w_idx;
  logic                  w_any;
  logic [AddrWidth-1:0]  w_sel_addr;

  beta_rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .i_req  (arb_req_i),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Grant is one-hot, so OR-ing the gated slices yields the winner's address.
  always_comb begin
    w_sel_addr = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (w_gnt[k]) begin
        w_sel_addr = w_sel_addr | arb_addr_i[k*AddrWidth +: AddrWidth];
      end
    end
  end

`ifdef BETA_IMEM_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0]   r_cnt;
  logic [NumReq-1:0] r_err;
  assign arb_err_o = r_err;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_last     <= IdxW'(NumReq - 1);
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
`ifdef BETA_IMEM_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= '0;
`endif
    end else begin
`ifdef BETA_IMEM_ARB_TIMEOUT_EN
      r_err <= '0;
`endif
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_grant    <= w_gnt;
            r_last     <= w_idx;
            r_mem_addr <= w_sel_addr;
            r_mem_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ARB_WRDY;
          end
        end
        ARB_WRDY: begin
          if (mem_ready_i) begin
            r_mem_req <= 1'b0;
            r_state   <= ARB_WVLD;
`ifdef BETA_IMEM_ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        ARB_WVLD: begin
          if (mem_valid_i) begin
            r_busy  <= 1'b0;
            r_state <= ARB_IDLE;
          end
`ifdef BETA_IMEM_ARB_TIMEOUT_EN
          else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
            r_err   <= r_grant;
            r_busy  <= 1'b0;
            r_state <= ARB_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_mem_addr;
  assign arb_busy_o  = r_busy;
  assign arb_ready_o = r_grant & {NumReq{(r_state == ARB_WRDY) & mem_ready_i}};
  assign arb_valid_o = r_grant & {NumReq{(r_state == ARB_WVLD) & mem_valid_i}};
  assign arb_rdata_o = (|arb_valid_o) ? mem_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_beta_imem_arbiter.sv
// ============================================================================
// Module   : tb_beta_imem_arbiter
// Brief    : Self-checking bench: vector table, hand sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_beta_imem_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic [NR-1:0]     arb_req_i;
  logic [NR*AW-1:0]  arb_addr_i;
  logic [NR-1:0]     arb_ready_o;
  logic [NR-1:0]     arb_valid_o;
  logic [DW-1:0]     arb_rdata_o;
  logic              arb_busy_o;
  logic              mem_req_o;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_ready_i;
  logic              mem_valid_i;
  logic [DW-1:0]     mem_rdata_i;
`ifdef BETA_IMEM_ARB_TIMEOUT_EN
  logic [NR-1:0]     arb_err_o;
`endif

  int total = 0;
  int bad   = 0;
  int m_last;

  always #5 clk_i = ~clk_i;

  beta_imem_arbiter #(
    .NumReq        (NR),
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .TimeoutCycles (8)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .arb_req_i   (arb_req_i),
    .arb_addr_i  (arb_addr_i),
    .arb_ready_o (arb_ready_o),
    .arb_valid_o (arb_valid_o),
    .arb_rdata_o (arb_rdata_o),
    .arb_busy_o  (arb_busy_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ready_i (mem_ready_i),
    .mem_valid_i (mem_valid_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef BETA_IMEM_ARB_TIMEOUT_EN
    ,
    .arb_err_o   (arb_err_o)
`endif
  );

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] rd;
    int          rdy;
    int          vld;
    bit          drop;
    bit          rst;
    int          win;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Spec rule: first set bit scanning from last+1 with wrap-around.
  function automatic int rr_pick(input logic [NR-1:0] req, input int last);
    for (int i = 1; i <= NR; i++) begin
      int k;
      k = (last + i) % NR;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rstn_i      = 1'b0;
    arb_req_i   = '0;
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;
    mem_rdata_i = '0;
    step();
    step();
    rstn_i = 1'b1;
    m_last = NR - 1;
  endtask

  task automatic run_txn(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] rd, input int rdy_dly, input int vld_dly,
                         input bit drop, input int exp_win);
    logic [1:0]  oh;
    logic [31:0] exp_addr;
    oh       = 2'b01 << exp_win;
    exp_addr = (exp_win == 1) ? a1 : a0;
    arb_req_i  = req;
    arb_addr_i = {a1, a0};
    #2;
    chk("idle_busy", {31'd0, arb_busy_o}, 32'd0);
    chk("idle_memreq", {31'd0, mem_req_o}, 32'd0);
    step();
    if (drop) arb_req_i = '0;
    arb_addr_i = ~arb_addr_i;
    for (int c = 0; c <= rdy_dly; c++) begin
      mem_ready_i = (c == rdy_dly);
      mem_valid_i = (c != rdy_dly);
      mem_rdata_i = $urandom;
      #2;
      chk("wrdy_memreq", {31'd0, mem_req_o}, 32'd1);
      chk("wrdy_addr", mem_addr_o, exp_addr);
      chk("wrdy_busy", {31'd0, arb_busy_o}, 32'd1);
      chk("wrdy_ready", {30'd0, arb_ready_o}, (c == rdy_dly) ? {30'd0, oh} : 32'd0);
      chk("wrdy_valid", {30'd0, arb_valid_o}, 32'd0);
      chk("wrdy_rdata", arb_rdata_o, 32'd0);
      step();
    end
    for (int c = 0; c <= vld_dly; c++) begin
      mem_valid_i = (c == vld_dly);
      mem_ready_i = (c != vld_dly);
      mem_rdata_i = (c == vld_dly) ? rd : $urandom;
      #2;
      chk("wvld_memreq", {31'd0, mem_req_o}, 32'd0);
      chk("wvld_busy", {31'd0, arb_busy_o}, 32'd1);
      chk("wvld_ready", {30'd0, arb_ready_o}, 32'd0);
      chk("wvld_valid", {30'd0, arb_valid_o}, (c == vld_dly) ? {30'd0, oh} : 32'd0);
      chk("wvld_rdata", arb_rdata_o, (c == vld_dly) ? rd : 32'd0);
      step();
    end
    mem_valid_i = 1'b0;
    mem_ready_i = 1'b0;
    m_last      = exp_win;
    #2;
    chk("done_busy", {31'd0, arb_busy_o}, 32'd0);
  endtask

  initial begin
    arb_addr_i = '0;
    do_reset();
    #2;
    chk("rst_memreq", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_busy", {31'd0, arb_busy_o}, 32'd0);
    chk("rst_ready", {30'd0, arb_ready_o}, 32'd0);
    chk("rst_valid", {30'd0, arb_valid_o}, 32'd0);
    chk("rst_rdata", arb_rdata_o, 32'd0);

    tbl[0] = '{2'b01, 32'h100,  32'h200,  32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 0};
    tbl[1] = '{2'b11, 32'h1000, 32'h2000, 32'h11111111, 0, 0, 1'b0, 1'b1, 0};
    tbl[2] = '{2'b11, 32'h1004, 32'h2004, 32'h22222222, 0, 0, 1'b0, 1'b0, 1};
    tbl[3] = '{2'b11, 32'h1008, 32'h2008, 32'h33333333, 0, 0, 1'b0, 1'b0, 0};
    tbl[4] = '{2'b11, 32'h100C, 32'h200C, 32'h44444444, 0, 0, 1'b0, 1'b0, 1};
    tbl[5] = '{2'b11, 32'hA000, 32'hB000, 32'h55AA55AA, 5, 7, 1'b0, 1'b0, 0};
    tbl[6] = '{2'b10, 32'hC000, 32'hD000, 32'h0BADF00D, 2, 1, 1'b1, 1'b0, 1};

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst) do_reset();
      run_txn(tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].rd,
              tbl[i].rdy, tbl[i].vld, tbl[i].drop, tbl[i].win);
    end

    // Reset while waiting for valid: response is dropped, priority restarts at 0.
    arb_req_i  = 2'b10;
    arb_addr_i = {32'hE000, 32'hF000};
    step();
    arb_req_i   = '0;
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    #2;
    chk("mid_busy", {31'd0, arb_busy_o}, 32'd1);
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
    m_last = NR - 1;
    #2;
    chk("mid_memreq", {31'd0, mem_req_o}, 32'd0);
    chk("mid_addr", mem_addr_o, 32'd0);
    chk("mid_busyclr", {31'd0, arb_busy_o}, 32'd0);
    mem_valid_i = 1'b1;
    mem_rdata_i = 32'hBAD0BAD0;
    #1;
    chk("mid_late_valid", {30'd0, arb_valid_o}, 32'd0);
    chk("mid_late_rdata", arb_rdata_o, 32'd0);
    step();
    mem_valid_i = 1'b0;
    run_txn(2'b11, 32'h300, 32'h400, 32'h12345678, 0, 0, 1'b0, 0);

`ifdef BETA_IMEM_ARB_TIMEOUT_EN
    begin
      int w;
      logic [1:0] woh;
      w   = rr_pick(2'b11, m_last);
      woh = 2'b01 << w;
      arb_req_i  = 2'b11;
      arb_addr_i = {32'h7000, 32'h6000};
      step();
      arb_req_i   = '0;
      m_last      = w;
      mem_ready_i = 1'b1;
      step();
      mem_ready_i = 1'b0;
      for (int c = 0; c < 8; c++) begin
        #2;
        chk("to_err_early", {30'd0, arb_err_o}, 32'd0);
        chk("to_busy", {31'd0, arb_busy_o}, 32'd1);
        step();
      end
      #2;
      chk("to_err", {30'd0, arb_err_o}, {30'd0, woh});
      chk("to_busyclr", {31'd0, arb_busy_o}, 32'd0);
      step();
      #2;
      chk("to_err_pulse", {30'd0, arb_err_o}, 32'd0);
      mem_valid_i = 1'b1;
      #1;
      chk("to_late_valid", {30'd0, arb_valid_o}, 32'd0);
      step();
      mem_valid_i = 1'b0;
    end
`endif

    // Random traffic against the rotating-priority model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] rq;
      int         gap;
      rq  = 2'($urandom_range(1, 3));
      run_txn(rq, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), rr_pick(rq, m_last));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        arb_req_i = '0;
        step();
        #2;
        chk("gap_busy", {31'd0, arb_busy_o}, 32'd0);
        chk("gap_memreq", {31'd0, mem_req_o}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
